friscv_io_arbiter: RTL and testbench
====================================

FRISCV_IO_ARBITER -- requirements
Module: friscv_io_arbiter

Interface
REQ-001 SHALL have parameter ADDRW, default 16, address width.
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, bus watchdog limit in cycles; 0 disables the watchdog.
REQ-004 SHALL have port aclk  in  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port areset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port srst  in  1  synchronous reset, active-high.
REQ-007 SHALL have ports reqN_en  in  1  transfer request, N in {0,1}, held high until reqN_ready.
REQ-008 SHALL have ports reqN_wr  in  1  1 = write, 0 = read.
REQ-009 SHALL have ports reqN_addr  in  ADDRW  address.
REQ-010 SHALL have ports reqN_wdata  in  XLEN  write data.
REQ-011 SHALL have ports reqN_strb  in  XLEN/8  byte strobes.
REQ-012 SHALL have ports reqN_rdata  out  XLEN  read data, valid with reqN_ready.
REQ-013 SHALL have ports reqN_ready  out  1  one-cycle completion pulse.
REQ-014 SHALL have ports reqN_err  out  1  timeout flag, valid with reqN_ready.
REQ-015 SHALL have ports mst_en, mst_wr, mst_addr, mst_wdata, mst_strb  out  1/1/ADDRW/XLEN/XLEN/8  shared IO bus request.
REQ-016 SHALL have ports mst_rdata  in  XLEN and mst_ready  in  1  shared IO bus response.
REQ-017 SHALL have port grant  out  1  index of requester owning the bus, valid while busy is high.
REQ-018 SHALL have port busy  out  1  high in BUSY and DONE.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-020 In IDLE with any reqN_en high, SHALL register the winner's wr/addr/wdata/strb onto mst_*, drive mst_en=1 from the next cycle and enter BUSY.
REQ-021 When both requesters are high in IDLE, SHALL grant the one selected by a round-robin pointer; the pointer resets to 0 and, after every completion, points to the requester that did not win.
REQ-022 When a single requester is high, SHALL grant it regardless of the pointer.
REQ-023 In BUSY, SHALL hold mst_* stable and ignore requester inputs.
REQ-024 On mst_ready=1 in BUSY, SHALL capture mst_rdata into the winner's reqN_rdata, set reqN_err=0, drop mst_en and enter DONE.
REQ-025 In DONE, SHALL pulse the winner's reqN_ready for exactly one cycle, ignore all reqN_en and return to IDLE.
REQ-026 Latency SHALL be as follows: reqN_en first seen at cycle 0 gives mst_en at cycle 1; mst_ready at cycle k gives reqN_ready at cycle k+1; the next grant is decided at cycle k+2.
REQ-027 With TIMEOUT>0, SHALL count BUSY cycles without mst_ready; at count==TIMEOUT it SHALL drop mst_en, set reqN_rdata=0 and reqN_err=1, and enter DONE.
REQ-028 mst_ready arriving in the same cycle the count reaches TIMEOUT SHALL take precedence (normal completion, err=0).
REQ-029 The watchdog counter SHALL clear on entry to BUSY and be $clog2(TIMEOUT+1) bits wide.
REQ-030 The non-winning requester's reqN_ready SHALL stay 0, and its reqN_rdata and reqN_err SHALL hold their last values.
REQ-031 mst_ready or mst_rdata received outside BUSY SHALL be ignored.

Reset
REQ-032 areset or srst SHALL force: state IDLE; pointer 0; counter 0; mst_en, mst_wr, mst_addr, mst_wdata, mst_strb = 0; reqN_ready, reqN_err, reqN_rdata = 0; grant 0; busy 0.
REQ-033 Reset during BUSY or DONE SHALL abort the transfer with no reqN_ready pulse; the requester re-issues after reset.

Structure
REQ-034 The FSM state enum and the requester-count constant SHALL reside in the shared friscv package.
REQ-035 The round-robin pointer plus grant logic SHALL be a sub-module named friscv_rr_arbiter (2 requesters).

Verification
REQ-036 Single read: req0 read addr 0x0004, slave returns ready at cycle 3 with 0xDEADBEEF -> mst_en cycles 1-3, req0_ready at cycle 4 with rdata 0xDEADBEEF, err 0.
REQ-037 Contention: req0 and req1 both request in the same cycle, both held repeatedly -> grants alternate 0,1,0,1; no ready pulses on the loser.
REQ-038 Timeout: TIMEOUT=8, req1 write, slave never ready -> mst_en high 8 cycles, then req1_ready=1 with err=1 and rdata 0, then FSM back in IDLE.
REQ-039 Boundary: mst_ready at exactly cycle TIMEOUT -> err=0, rdata captured.
REQ-040 Reset mid-op: areset asserted in BUSY -> all outputs 0 immediately, no reqN_ready, pointer 0.
REQ-041 Back-to-back: req0 re-asserts en in the cycle after ready, slave returns zero-wait ready -> one transfer per 3 cycles, with no stale re-grant during DONE.

Source files
------------

// File: rtl/friscv_pkg.sv
// Shared definitions for the friscv IO arbiter slice.
//   NbReq       : number of requesters sharing the IO bus
//   arb_state_e : arbiter FSM states
package friscv_pkg;

    localparam int unsigned NbReq = 2;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } arb_state_e;

endpackage

// File: rtl/friscv_rr_arbiter.sv
// Two-requester round-robin grant selection.
//   aclk, areset, srst : clock, async reset, sync reset (both active-high)
//   req_i              : pending requests, one bit per requester
//   update_i           : a transfer completed this cycle
//   owner_i            : requester that owned the completed transfer
//   gnt_o              : index of the requester to grant now
module friscv_rr_arbiter
    import friscv_pkg::*;
(
    input  logic             aclk,
    input  logic             areset,
    input  logic             srst,
    input  logic [NbReq-1:0] req_i,
    input  logic             update_i,
    input  logic             owner_i,
    output logic             gnt_o
);

    // Points at the requester favoured on the next tie.
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (srst) begin
            ptr_d = 1'b0;
        end else if (update_i) begin
            ptr_d = ~owner_i;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // A lone requester wins regardless of the pointer.
    assign gnt_o = (&req_i) ? ptr_q : req_i[1];

endmodule

// File: rtl/friscv_io_arbiter.sv
// Arbitrates two requesters onto one shared IO bus, one transfer at a time,
// with an optional watchdog that aborts a transfer the slave never answers.
//   aclk, areset, srst    : clock, async reset, sync reset (both active-high)
//   reqN_en/wr/addr/...   : requester N transfer request (held until reqN_ready)
//   reqN_rdata/ready/err  : requester N completion (ready is a 1-cycle pulse)
//   mst_*                 : shared IO bus request / response
//   grant, busy           : current owner index and transfer-in-flight flag
module friscv_io_arbiter
    import friscv_pkg::*;
#(
    parameter int unsigned ADDRW   = 16,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              srst,
    input  logic              req0_en,
    input  logic              req0_wr,
    input  logic [ADDRW-1:0]  req0_addr,
    input  logic [XLEN-1:0]   req0_wdata,
    input  logic [XLEN/8-1:0] req0_strb,
    output logic [XLEN-1:0]   req0_rdata,
    output logic              req0_ready,
    output logic              req0_err,
    input  logic              req1_en,
    input  logic              req1_wr,
    input  logic [ADDRW-1:0]  req1_addr,
    input  logic [XLEN-1:0]   req1_wdata,
    input  logic [XLEN/8-1:0] req1_strb,
    output logic [XLEN-1:0]   req1_rdata,
    output logic              req1_ready,
    output logic              req1_err,
    output logic              mst_en,
    output logic              mst_wr,
    output logic [ADDRW-1:0]  mst_addr,
    output logic [XLEN-1:0]   mst_wdata,
    output logic [XLEN/8-1:0] mst_strb,
    input  logic [XLEN-1:0]   mst_rdata,
    input  logic              mst_ready,
    output logic              grant,
    output logic              busy
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value during the BUSY cycle in which the count reaches TIMEOUT.
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              wr_q, wr_d;
    logic [ADDRW-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN/8-1:0] strb_q, strb_d;
    logic [XLEN-1:0]   rdata_q [NbReq];
    logic [XLEN-1:0]   rdata_d [NbReq];
    logic [NbReq-1:0]  ready_q, ready_d;
    logic [NbReq-1:0]  err_q, err_d;

    logic [NbReq-1:0]  req_en;
    logic              rr_gnt;
    logic              rr_update;
    logic              timeout_hit;

    assign req_en      = {req1_en, req0_en};
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

    friscv_rr_arbiter u_rr (
        .aclk     (aclk),
        .areset   (areset),
        .srst     (srst),
        .req_i    (req_en),
        .update_i (rr_update),
        .owner_i  (grant_q),
        .gnt_o    (rr_gnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        ready_d   = '0;
        err_d     = err_q;
        rr_update = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req_en) begin
                    grant_d = rr_gnt;
                    wr_d    = rr_gnt ? req1_wr    : req0_wr;
                    addr_d  = rr_gnt ? req1_addr  : req0_addr;
                    wdata_d = rr_gnt ? req1_wdata : req0_wdata;
                    strb_d  = rr_gnt ? req1_strb  : req0_strb;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // A response in the watchdog's last cycle still completes normally.
                if (mst_ready) begin
                    rdata_d[grant_q] = mst_rdata;
                    err_d[grant_q]   = 1'b0;
                    ready_d[grant_q] = 1'b1;
                    rr_update        = 1'b1;
                    state_d          = StDone;
                end else if (timeout_hit) begin
                    rdata_d[grant_q] = '0;
                    err_d[grant_q]   = 1'b1;
                    ready_d[grant_q] = 1'b1;
                    rr_update        = 1'b1;
                    state_d          = StDone;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (srst) begin
            state_d = StIdle;
            cnt_d   = '0;
            grant_d = 1'b0;
            wr_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            strb_d  = '0;
            ready_d = '0;
            err_d   = '0;
            for (int i = 0; i < NbReq; i++) begin
                rdata_d[i] = '0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            ready_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < NbReq; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            for (int i = 0; i < NbReq; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    assign mst_en     = (state_q == StBusy);
    assign busy       = (state_q != StIdle);
    assign grant      = grant_q;
    assign mst_wr     = wr_q;
    assign mst_addr   = addr_q;
    assign mst_wdata  = wdata_q;
    assign mst_strb   = strb_q;
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];
    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];

endmodule

// File: tb/tb_friscv_io_arbiter.sv
// Directed self-checking bench for friscv_io_arbiter (TIMEOUT = 8).
module tb_friscv_io_arbiter;

    localparam int unsigned ADDRW   = 16;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 8;

    logic              aclk;
    logic              areset;
    logic              srst;
    logic              req0_en, req0_wr, req1_en, req1_wr;
    logic [ADDRW-1:0]  req0_addr, req1_addr;
    logic [XLEN-1:0]   req0_wdata, req1_wdata;
    logic [XLEN/8-1:0] req0_strb, req1_strb;
    logic [XLEN-1:0]   req0_rdata, req1_rdata;
    logic              req0_ready, req0_err, req1_ready, req1_err;
    logic              mst_en, mst_wr;
    logic [ADDRW-1:0]  mst_addr;
    logic [XLEN-1:0]   mst_wdata;
    logic [XLEN/8-1:0] mst_strb;
    logic [XLEN-1:0]   mst_rdata;
    logic              mst_ready;
    logic              grant, busy;

    int n_checks = 0;
    int n_fail   = 0;

    friscv_io_arbiter #(
        .ADDRW   (ADDRW),
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .srst       (srst),
        .req0_en    (req0_en),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_strb  (req0_strb),
        .req0_rdata (req0_rdata),
        .req0_ready (req0_ready),
        .req0_err   (req0_err),
        .req1_en    (req1_en),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_strb  (req1_strb),
        .req1_rdata (req1_rdata),
        .req1_ready (req1_ready),
        .req1_err   (req1_err),
        .mst_en     (mst_en),
        .mst_wr     (mst_wr),
        .mst_addr   (mst_addr),
        .mst_wdata  (mst_wdata),
        .mst_strb   (mst_strb),
        .mst_rdata  (mst_rdata),
        .mst_ready  (mst_ready),
        .grant      (grant),
        .busy       (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Outputs are all register-driven, so sampling 1 time unit after the edge is safe.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; srst = 1'b0;
        req0_en = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0; req0_strb = '0;
        req1_en = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0; req1_strb = '0;
        mst_ready = 0; mst_rdata = '0;
        #12;
        n_checks++;
        if ({busy, mst_en, grant} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: busy/mst_en/grant got %b want 000", {busy, mst_en, grant});
        end
        n_checks++;
        if ({req0_ready, req1_ready, req0_err, req1_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {req0_ready, req1_ready, req0_err, req1_err});
        end
        n_checks++;
        if ({req0_rdata, req1_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", {req0_rdata, req1_rdata});
        end
        n_checks++;
        if ({mst_wr, mst_addr, mst_wdata, mst_strb} !== 53'h0) begin
            n_fail++; $display("FAIL reset_mst: got %h want 0", {mst_wr, mst_addr, mst_wdata, mst_strb});
        end
        @(negedge aclk);
        areset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        req0_en = 1; req0_wr = 0; req0_addr = 16'h0004;
        tick(); // cycle 1
        n_checks++;
        if ({mst_en, busy, grant, mst_wr} !== 4'b1100 || mst_addr !== 16'h0004) begin
            n_fail++; $display("FAIL read_issue: en/busy/grant/wr %b addr %h want 1100 0004", {mst_en, busy, grant, mst_wr}, mst_addr);
        end
        tick(); // cycle 2
        n_checks++;
        if (mst_en !== 1'b1) begin n_fail++; $display("FAIL read_en_c2: got %b want 1", mst_en); end
        tick(); // cycle 3
        n_checks++;
        if (mst_en !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++; $display("FAIL read_c3: en %b ready %b want 1 0", mst_en, req0_ready);
        end
        mst_ready = 1; mst_rdata = 32'hDEADBEEF;
        tick(); // cycle 4
        mst_ready = 0; mst_rdata = '0;
        n_checks++;
        if (req0_ready !== 1'b1 || req0_rdata !== 32'hDEADBEEF || req0_err !== 1'b0) begin
            n_fail++; $display("FAIL read_done: ready %b rdata %h err %b want 1 deadbeef 0", req0_ready, req0_rdata, req0_err);
        end
        n_checks++;
        if (mst_en !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL read_done_ctrl: en %b r1 %b busy %b want 0 0 1", mst_en, req1_ready, busy);
        end
        req0_en = 0;
        tick(); // cycle 5
        n_checks++;
        if (req0_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL read_pulse_end: ready %b busy %b want 0 0", req0_ready, busy);
        end
    endtask

    task automatic test_contention();
        int budget;
        logic exp_g;
        logic [XLEN-1:0] exp_d;
        srst = 1;
        tick();
        srst = 0;
        n_checks++;
        if (busy !== 1'b0 || req0_rdata !== 32'h0) begin
            n_fail++; $display("FAIL srst_clear: busy %b rdata0 %h want 0 0", busy, req0_rdata);
        end
        req0_en = 1; req0_wr = 0; req0_addr = 16'h1000;
        req1_en = 1; req1_wr = 1; req1_addr = 16'h2000; req1_wdata = 32'h22; req1_strb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            budget = 0;
            while (mst_en !== 1'b1 && budget < 10) begin tick(); budget++; end
            n_checks++;
            if (mst_en !== 1'b1) begin n_fail++; $display("FAIL cont_wait_%0d: mst_en %b want 1", i, mst_en); end
            exp_g = (i % 2) == 1;
            exp_d = 32'hC0DE0000 + 32'(i);
            n_checks++;
            if (grant !== exp_g || mst_addr !== (exp_g ? 16'h2000 : 16'h1000)) begin
                n_fail++; $display("FAIL cont_grant_%0d: grant %b addr %h want %b", i, grant, mst_addr, exp_g);
            end
            mst_ready = 1; mst_rdata = exp_d;
            tick();
            mst_ready = 0;
            n_checks++;
            if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL cont_ready_%0d: r1r0 %b want %b", i, {req1_ready, req0_ready}, exp_g ? 2'b10 : 2'b01);
            end
            n_checks++;
            if ((exp_g ? req1_rdata : req0_rdata) !== exp_d) begin
                n_fail++; $display("FAIL cont_rdata_%0d: got %h want %h", i, exp_g ? req1_rdata : req0_rdata, exp_d);
            end
            if (i > 0) begin
                n_checks++;
                if ((exp_g ? req0_rdata : req1_rdata) !== exp_d - 32'd1) begin
                    n_fail++; $display("FAIL cont_hold_%0d: got %h want %h", i, exp_g ? req0_rdata : req1_rdata, exp_d - 32'd1);
                end
            end
            tick();
        end
        req0_en = 0; req1_en = 0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_end: busy %b want 0", busy); end
    endtask

    task automatic test_timeout();
        int highs;
        req1_en = 1; req1_wr = 1; req1_addr = 16'h0ABC; req1_wdata = 32'h12345678; req1_strb = 4'b0011;
        tick(); // cycle 1
        n_checks++;
        if ({grant, mst_wr} !== 2'b11 || mst_addr !== 16'h0ABC || mst_wdata !== 32'h12345678 || mst_strb !== 4'b0011) begin
            n_fail++; $display("FAIL to_issue: grant/wr %b addr %h wdata %h strb %b", {grant, mst_wr}, mst_addr, mst_wdata, mst_strb);
        end
        highs = 0;
        for (int c = 0; c < 8; c++) begin
            if (mst_en === 1'b1) highs++;
            tick();
        end
        // now in cycle 9
        n_checks++;
        if (highs != 8 || mst_en !== 1'b0) begin
            n_fail++; $display("FAIL to_en_len: high %0d cycles, en %b after; want 8 and 0", highs, mst_en);
        end
        n_checks++;
        if (req1_ready !== 1'b1 || req1_err !== 1'b1 || req1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_done: ready %b err %b rdata %h want 1 1 0", req1_ready, req1_err, req1_rdata);
        end
        n_checks++;
        if (req0_ready !== 1'b0 || req0_rdata !== 32'hC0DE0002) begin
            n_fail++; $display("FAIL to_loser: ready %b rdata %h want 0 c0de0002", req0_ready, req0_rdata);
        end
        req1_en = 0;
        tick(); // cycle 10
        n_checks++;
        if (busy !== 1'b0 || req1_ready !== 1'b0 || req1_err !== 1'b1) begin
            n_fail++; $display("FAIL to_idle: busy %b ready %b err %b want 0 0 1", busy, req1_ready, req1_err);
        end
        // Stray response while idle.
        mst_ready = 1; mst_rdata = 32'hFFFFFFFF;
        tick();
        mst_ready = 0; mst_rdata = '0;
        n_checks++;
        if ({busy, req0_ready, req1_ready} !== 3'b000 || req1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL stray_ready: busy/r0/r1 %b rdata1 %h want 000 0", {busy, req0_ready, req1_ready}, req1_rdata);
        end
    endtask

    task automatic test_boundary();
        req0_en = 1; req0_wr = 0; req0_addr = 16'h0040;
        tick(); // cycle 1
        for (int c = 1; c < 8; c++) tick();
        // cycle 8: count reaches TIMEOUT here
        n_checks++;
        if (mst_en !== 1'b1) begin n_fail++; $display("FAIL bnd_en_c8: got %b want 1", mst_en); end
        mst_ready = 1; mst_rdata = 32'h55AA55AA;
        tick();
        mst_ready = 0; mst_rdata = '0;
        n_checks++;
        if (req0_ready !== 1'b1 || req0_err !== 1'b0 || req0_rdata !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL bnd_done: ready %b err %b rdata %h want 1 0 55aa55aa", req0_ready, req0_err, req0_rdata);
        end
        req0_en = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        req0_en = 1; req0_addr = 16'h0080;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
        #3 areset = 1;
        #1;
        n_checks++;
        if ({busy, mst_en, grant, req0_ready, req1_ready, req0_err, req1_err} !== 7'b0) begin
            n_fail++; $display("FAIL mid_ctrl: got %b want 0", {busy, mst_en, grant, req0_ready, req1_ready, req0_err, req1_err});
        end
        n_checks++;
        if (req0_rdata !== 32'h0 || mst_addr !== 16'h0) begin
            n_fail++; $display("FAIL mid_data: rdata0 %h addr %h want 0 0", req0_rdata, mst_addr);
        end
        tick();
        areset = 0; req0_en = 0;
        tick();
        n_checks++;
        if ({busy, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_after: busy/ready %b want 00", {busy, req0_ready}); end
        // Pointer was 1 before reset; a tie must now go to requester 0.
        req0_en = 1; req0_addr = 16'h0100; req1_en = 1; req1_addr = 16'h0200;
        tick();
        n_checks++;
        if (grant !== 1'b0 || mst_addr !== 16'h0100) begin
            n_fail++; $display("FAIL mid_ptr: grant %b addr %h want 0 0100", grant, mst_addr);
        end
        mst_ready = 1; mst_rdata = 32'h11;
        tick();
        mst_ready = 0;
        n_checks++;
        if (req0_ready !== 1'b1 || req0_rdata !== 32'h11) begin
            n_fail++; $display("FAIL mid_xfer: ready %b rdata %h want 1 11", req0_ready, req0_rdata);
        end
        req0_en = 0; req1_en = 0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        req0_en = 1; req0_addr = 16'h0300; req1_en = 0;
        tick(); // cycle 1
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mst_en !== 1'b1 || grant !== 1'b0) begin
                n_fail++; $display("FAIL b2b_issue_%0d: en %b grant %b want 1 0", i, mst_en, grant);
            end
            mst_ready = 1; mst_rdata = 32'h100 + 32'(i);
            tick();
            mst_ready = 0;
            n_checks++;
            if (req0_ready !== 1'b1 || req0_rdata !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL b2b_done_%0d: ready %b rdata %h want 1 %h", i, req0_ready, req0_rdata, 32'h100 + 32'(i));
            end
            tick();
            n_checks++;
            if ({busy, mst_en, req0_ready} !== 3'b000) begin
                n_fail++; $display("FAIL b2b_idle_%0d: busy/en/ready %b want 000", i, {busy, mst_en, req0_ready});
            end
            if (i == 2) req0_en = 0;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000 reached");
        $fatal(1, "bench time limit expired");
    end

endmodule
